// File: rtl/im_loader_if.sv
// im_loader_if: host-side byte stream, control and IM write port of the instruction
// memory loader, bundled into one interface.
//
//   start, load_len        host -> loader  load request and word count
//   byte_in, byte_valid    host -> loader  big-endian byte stream
//   byte_ready             loader -> host  loader accepts a byte this cycle
//   we, waddr, wdata       loader -> IM    one-cycle word write
//   busy, done, err        loader -> host  status
//
// The host (or testbench) takes the master modport; the loader takes the slave modport.
interface im_loader_if #(
  parameter int unsigned LENW = 11
) ();

  logic            start;
  logic [LENW-1:0] load_len;
  logic [7:0]      byte_in;
  logic            byte_valid;
  logic            byte_ready;
  logic            we;
  logic [31:0]     waddr;
  logic [31:0]     wdata;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output start,
    output load_len,
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  we,
    input  waddr,
    input  wdata,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  load_len,
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output we,
    output waddr,
    output wdata,
    output busy,
    output done,
    output err
  );

endinterface

// File: rtl/im_loader.sv
// im_loader: write-side companion of the instruction memory. Accepts a byte stream,
// packs it into big-endian 32-bit words and issues one-cycle writes into the IM,
// starting at BASE and advancing one word per write.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    im_loader_if.slave: start/load_len in, byte_in/byte_valid in,
//          byte_ready out, we/waddr/wdata out, busy/done/err out
//
// Parameters:
//   BASE   byte address of the first word written
//   DEPTH  IM capacity in words (largest legal load_len)
//   LENW   width of load_len; must be able to hold DEPTH
//
// Every output is a register. A load runs RECV (4 byte accepts) -> WRITE (1 cycle)
// per word, so throughput is at most one word per 5 cycles.
module im_loader #(
  parameter logic [31:0] BASE  = 32'h0000_3000,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LENW  = 11
) (
  input logic        clk,
  input logic        reset,
  im_loader_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [LENW-1:0] word_cnt_q, word_cnt_d;
  logic [LENW-1:0] len_q, len_d;
  logic [31:0]     asm_q, asm_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            byte_ready_q, byte_ready_d;
  logic            we_q, we_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            byte_acc;
  logic [31:0]     asm_next;
  logic [LENW-1:0] word_cnt_inc;
  logic            len_zero;
  logic            len_over;

  // byte_ready is registered, so the handshake uses the value the host saw this cycle.
  assign byte_acc     = bus.byte_valid && byte_ready_q;
  assign asm_next     = {asm_q[23:0], bus.byte_in};
  assign word_cnt_inc = word_cnt_q + LENW'(1);
  assign len_zero     = (bus.load_len == '0);
  assign len_over     = (32'(bus.load_len) > DEPTH);

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    len_d        = len_q;
    asm_d        = asm_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    byte_ready_d = byte_ready_q;
    we_d         = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          if (len_over) begin
            // Rejected request: nothing is written and no stream is opened.
            state_d = StIdle;
            err_d   = 1'b1;
          end else if (len_zero) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d      = StRecv;
            byte_cnt_d   = 2'd0;
            word_cnt_d   = '0;
            len_d        = bus.load_len;
            asm_d        = '0;
            waddr_d      = BASE;
            busy_d       = 1'b1;
            byte_ready_d = 1'b1;
          end
        end
      end

      StRecv: begin
        if (byte_acc) begin
          asm_d      = asm_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Fourth byte: the word is complete, so present the write immediately and
            // close the stream for the WRITE cycle.
            state_d      = StWrite;
            byte_ready_d = 1'b0;
            we_d         = 1'b1;
            wdata_d      = asm_next;
          end
        end
      end

      StWrite: begin
        word_cnt_d = word_cnt_inc;
        if (word_cnt_inc == len_q) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d      = StRecv;
          byte_ready_d = 1'b1;
          waddr_d      = waddr_q + 32'd4;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      byte_cnt_q   <= 2'd0;
      word_cnt_q   <= '0;
      len_q        <= '0;
      asm_q        <= '0;
      waddr_q      <= BASE;
      wdata_q      <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      len_q        <= len_d;
      asm_q        <= asm_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

  // A write cycle never overlaps byte acceptance and only happens mid-load.
  a_we_not_ready: assert property (@(posedge clk) disable iff (!reset) we_q |-> !byte_ready_q);
  a_we_busy:      assert property (@(posedge clk) disable iff (!reset) we_q |-> busy_q);

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Write-side counterpart of the instruction memory: accepts a byte stream from a host/debug link, assembles big-endian 32-bit instruction words and issues one-cycle word writes into the IM array.
- Write addresses start at the IM base 0x0000_3000; the IM slot index is waddr[11:2] after subtracting the base.
- Sits between the host byte interface and the IM write port; the CPU is held off while busy=1.

Parameters:
- BASE, 32'h0000_3000, byte address of the first word written.
- DEPTH, 1024, IM capacity in words.
- LENW, 11, width of load_len; must hold the value DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- load_len  in  LENW  number of words to load; sampled with start.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader can accept a byte this cycle.
- we  out  1  IM write strobe, one cycle per word.
- waddr  out  32  byte address of the word being written.
- wdata  out  32  assembled instruction word.
- busy  out  1  load in progress (RECV or WRITE).
- done  out  1  last load completed; held until the next accepted start.
- err  out  1  last start was rejected (load_len > DEPTH); held until the next start.

Behaviour:
- All outputs are registered. Reset (reset=0, asynchronous) forces:
  - state=IDLE; byte_ready=0, we=0, busy=0, done=0, err=0;
  - waddr=BASE, wdata=0; byte and word counters=0.
  - Reset mid-load discards any partial word; no write is issued.
- States: IDLE, RECV, WRITE, DONE.
- IDLE/DONE, on start=1:
  - load_len=0: go to DONE, done=1, err=0, no write.
  - load_len>DEPTH: go to IDLE, err=1, done=0, no write.
  - Otherwise: go to RECV; clear counters; waddr=BASE; err=0, done=0; busy=1 and byte_ready=1 from the next cycle.
- start while busy=1 is ignored, and load_len is not re-sampled.
- RECV: byte_ready=1. A byte is accepted only when byte_valid && byte_ready.
  - Assembly register shifts left 8 and inserts byte_in in [7:0]; the first byte lands in [31:24] after four shifts.
  - byte_valid gaps are allowed; there is no timeout.
  - On acceptance of the 4th byte: go to WRITE, byte_ready=0 in the same registered update.
- WRITE: exactly one cycle.
  - we=1, waddr = BASE + 4*word_cnt, wdata = assembled word, byte_ready=0.
  - Next cycle: word_cnt+1; if equal to load_len, go to DONE (busy=0, done=1); otherwise go to RECV with waddr+4.
- Throughput: at most 1 word per 5 cycles (4 accepts + 1 write).
- we never asserts outside WRITE. wdata/waddr hold their last values when we=0.
- Address arithmetic is 32-bit, no wrap: at most DEPTH words, so the last address is BASE+4*(DEPTH-1).
- Bytes presented while byte_ready=0 are not consumed; the host keeps them valid.

Test Plan:
- Reset: hold reset=0 with random inputs -> byte_ready=0, we=0, busy=0, done=0, err=0, waddr=0x3000, wdata=0.
- start, load_len=2; bytes 3C 08 00 01 34 09 00 10 back-to-back -> we at waddr 0x3000, wdata 0x3C080001; then we at 0x3004, wdata 0x34090010; done=1, busy=0; 10 cycles from first byte to done.
- Same load with byte_valid toggling every other cycle, plus a start pulse mid-load -> identical writes; the start has no effect; byte_ready=0 during each WRITE cycle.
- start, load_len=0 -> done=1 next cycle, no we. start, load_len=1025 -> err=1, done=0, no we, byte_ready stays 0.
- reset=0 after 2 bytes of word 0 -> immediate reset values. New load of 1 word, bytes AA BB CC DD -> single write 0xAABBCCDD at 0x3000.
- load_len=1024 with incrementing data -> 1024 writes, last waddr 0x3FFC, done=1, no 1025th write.
